// File: rtl/phoenix_pkg.sv
// Shared definitions for the phoenix core EX stage: forward selects,
// multiply/divide unit states, RV32M funct3 encodings and a magnitude helper.
package phoenix_pkg;

    localparam int XLEN = 32;

    // Operand forward select; 2'b11 is not named and is treated as FWD_RF.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_MUL  = 2'b01,
        MD_DIV  = 2'b10,
        MD_DONE = 2'b11
    } muldiv_state_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Absolute value when the operand is interpreted as signed, else unchanged.
    // The most negative value maps to itself, which is its correct unsigned magnitude.
    function automatic logic [XLEN-1:0] mag_of(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, MSB first,
// 32 iterations after a start pulse. The quotient register starts out holding
// the dividend and shifts quotient bits in as dividend bits shift out.
module muldiv_divider
    import phoenix_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            kill,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dsr_q, dsr_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            busy_q, busy_d;

    logic [XLEN:0]   r_sh;
    logic [XLEN:0]   diff;

    // Load on start, otherwise run one restoring step per cycle while busy.
    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        dsr_d  = dsr_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        r_sh   = {rem_q, quo_q[XLEN-1]};
        diff   = r_sh - {1'b0, dsr_q};
        if (start) begin
            quo_d  = dividend;
            rem_d  = '0;
            dsr_d  = divisor;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (!diff[XLEN]) begin
                rem_d = diff[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_d = r_sh[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                busy_d = 1'b0;
            end
        end
        if (kill) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // High during the cycle whose edge completes the final iteration.
    assign done      = busy_q && (cnt_q == 5'd31);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage RV32M unit. Selects forwarded operands, latches them at accept,
// runs multiplies in two cycles and divides through muldiv_divider, and
// stalls the front of the pipeline while busy.
// Optional: define MULDIV_EARLY_OUT_EN to let trivial divides (|a|<|b|,
// divide by zero, signed overflow) skip the iterative divider.
// Handshake: result is meaningful only while result_valid=1; it is held
// stable in DONE for as long as ex_hold=1 and retires on the first cycle
// with ex_hold=0. Only XLEN=32 is supported.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_ex,
    input  logic            is_muldiv_ex,
    input  logic [2:0]      funct3_ex,
    input  logic [XLEN-1:0] rs1_data_ex,
    input  logic [XLEN-1:0] rs2_data_ex,
    input  logic [XLEN-1:0] alu_result_mem,
    input  logic [XLEN-1:0] wb_data_wb,
    input  logic [1:0]      forward_a,
    input  logic [1:0]      forward_b,
    input  logic            ex_hold,
    input  logic            flush_ex,
    output logic            stall_ex,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);
    import phoenix_pkg::*;

    muldiv_state_e     state_q, state_d;
    logic [XLEN-1:0]   op_a_q, op_a_d;
    logic [XLEN-1:0]   op_b_q, op_b_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [2*XLEN-1:0] product_q, product_d;
    logic              early_q, early_d;

    logic [XLEN-1:0]   sel_a, sel_b;
    logic              accept;
    logic              sgn_in;
    logic [XLEN-1:0]   mag_a_in, mag_b_in;
    logic              div_start;
    logic              div_done;
    logic [XLEN-1:0]   div_quo, div_rem;
`ifdef MULDIV_EARLY_OUT_EN
    logic              early_cond;
`endif

    logic              mul_sa, mul_sb;
    logic [2*XLEN-1:0] mul_a64, mul_b64, mul_product;

    logic              sgn_q;
    logic [XLEN-1:0]   mag_a_q, q_mag, r_mag, quo_c, rem_c, result_c;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    // Forward muxes; select 2'b11 falls back to the register file.
    always_comb begin
        case (forward_a)
            FWD_MEM: sel_a = alu_result_mem;
            FWD_WB:  sel_a = wb_data_wb;
            default: sel_a = rs1_data_ex;
        endcase
        case (forward_b)
            FWD_MEM: sel_b = alu_result_mem;
            FWD_WB:  sel_b = wb_data_wb;
            default: sel_b = rs2_data_ex;
        endcase
    end

    // Accept condition and the divide magnitudes handed to the divider at issue.
    always_comb begin
        accept   = (state_q == MD_IDLE) && valid_ex && is_muldiv_ex && !flush_ex;
        sgn_in   = ~funct3_ex[0];
        mag_a_in = mag_of(sel_a, sgn_in);
        mag_b_in = mag_of(sel_b, sgn_in);
`ifdef MULDIV_EARLY_OUT_EN
        early_cond = (mag_a_in < mag_b_in) || (sel_b == '0) ||
                     (sgn_in && (sel_a == MIN_INT) && (sel_b == '1));
`endif
    end

    // Full 64-bit product from the latched operands; signedness from funct3.
    always_comb begin
        mul_sa      = (funct3_q != F3_MULHU);
        mul_sb      = (funct3_q == F3_MUL) || (funct3_q == F3_MULH);
        mul_a64     = {{XLEN{mul_sa & op_a_q[XLEN-1]}}, op_a_q};
        mul_b64     = {{XLEN{mul_sb & op_b_q[XLEN-1]}}, op_b_q};
        mul_product = mul_a64 * mul_b64;
    end

    // Next-state and register-update logic; flush overrides everything.
    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        funct3_d  = funct3_q;
        product_d = product_q;
        early_d   = early_q;
        div_start = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (accept) begin
                    op_a_d   = sel_a;
                    op_b_d   = sel_b;
                    funct3_d = funct3_ex;
                    early_d  = 1'b0;
                    if (!funct3_ex[2]) begin
                        state_d = MD_MUL;
                    end else begin
`ifdef MULDIV_EARLY_OUT_EN
                        if (early_cond) begin
                            state_d = MD_DONE;
                            early_d = 1'b1;
                        end else
`endif
                        begin
                            state_d   = MD_DIV;
                            div_start = 1'b1;
                        end
                    end
                end
            end
            MD_MUL: begin
                product_d = mul_product;
                state_d   = MD_DONE;
            end
            MD_DIV: begin
                if (div_done) begin
                    state_d = MD_DONE;
                end
            end
            MD_DONE: begin
                if (!ex_hold) begin
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
        if (flush_ex) begin
            state_d   = MD_IDLE;
            op_a_d    = '0;
            op_b_d    = '0;
            funct3_d  = '0;
            product_d = '0;
            early_d   = 1'b0;
            div_start = 1'b0;
        end
    end

    // State and latched-operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MD_IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            funct3_q  <= '0;
            product_q <= '0;
            early_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            funct3_q  <= funct3_d;
            product_q <= product_d;
            early_q   <= early_d;
        end
    end

    muldiv_divider u_divider (
        .clk       (clk),
        .rst       (rst),
        .kill      (flush_ex),
        .start     (div_start),
        .dividend  (mag_a_in),
        .divisor   (mag_b_in),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Sign correction, special cases and final result selection in DONE.
    always_comb begin
        sgn_q   = ~funct3_q[0];
        mag_a_q = mag_of(op_a_q, sgn_q);
        q_mag   = early_q ? '0 : div_quo;
        r_mag   = early_q ? mag_a_q : div_rem;
        quo_c   = (sgn_q && (op_a_q[XLEN-1] ^ op_b_q[XLEN-1])) ? -q_mag : q_mag;
        rem_c   = (sgn_q && op_a_q[XLEN-1]) ? -r_mag : r_mag;
        if (op_b_q == '0) begin
            quo_c = '1;
            rem_c = op_a_q;
        end else if (sgn_q && (op_a_q == MIN_INT) && (op_b_q == '1)) begin
            quo_c = MIN_INT;
            rem_c = '0;
        end
        result_c = '0;
        if (state_q == MD_DONE) begin
            if (funct3_q[2]) begin
                result_c = funct3_q[1] ? rem_c : quo_c;
            end else if (funct3_q == F3_MUL) begin
                result_c = product_q[XLEN-1:0];
            end else begin
                result_c = product_q[2*XLEN-1:XLEN];
            end
        end
    end

    assign stall_ex     = accept || (state_q == MD_MUL) || (state_q == MD_DIV);
    assign result_valid = (state_q == MD_DONE);
    assign result       = result_c;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: forwarding, multiplies, divides,
// special cases, flush, hold in DONE and reset mid-divide.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_ex;
    logic        is_muldiv_ex;
    logic [2:0]  funct3_ex;
    logic [31:0] rs1_data_ex, rs2_data_ex, alu_result_mem, wb_data_wb;
    logic [1:0]  forward_a, forward_b;
    logic        ex_hold, flush_ex;
    logic        stall_ex, result_valid;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_ex       (valid_ex),
        .is_muldiv_ex   (is_muldiv_ex),
        .funct3_ex      (funct3_ex),
        .rs1_data_ex    (rs1_data_ex),
        .rs2_data_ex    (rs2_data_ex),
        .alu_result_mem (alu_result_mem),
        .wb_data_wb     (wb_data_wb),
        .forward_a      (forward_a),
        .forward_b      (forward_b),
        .ex_hold        (ex_hold),
        .flush_ex       (flush_ex),
        .stall_ex       (stall_ex),
        .result_valid   (result_valid),
        .result         (result)
    );

    // clock / reset block
    always #5 clk = ~clk;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int SPECIAL_STALL = 1;
`else
    localparam int SPECIAL_STALL = 33;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        valid_ex     = 1'b0;
        is_muldiv_ex = 1'b0;
        funct3_ex    = 3'd0;
        forward_a    = 2'b00;
        forward_b    = 2'b00;
        ex_hold      = 1'b0;
        flush_ex     = 1'b0;
    endtask

    // Issue one op, count stall cycles until DONE, hold DONE for `hold` cycles.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] fa, input logic [1:0] fb,
                          input logic [31:0] exp, input int exp_stall, input int hold);
        int n;
        bit got;
        valid_ex     = 1'b1;
        is_muldiv_ex = 1'b1;
        funct3_ex    = f3;
        rs1_data_ex  = a;
        rs2_data_ex  = b;
        forward_a    = fa;
        forward_b    = fb;
        #1;
        n   = 0;
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            if (result_valid) begin
                got = 1'b1;
            end else begin
                if (stall_ex) n++;
                tick();
            end
        end
        chk({tag, "_reached_done"}, 32'(got), 32'd1);
        chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
        for (int h = 0; h <= hold; h++) begin
            ex_hold = (h < hold);
            #1;
            chk({tag, "_valid"}, 32'(result_valid), 32'd1);
            chk({tag, "_result"}, result, exp);
            chk({tag, "_stall_in_done"}, 32'(stall_ex), 32'd0);
            tick();
        end
        idle_inputs();
        #1;
        chk({tag, "_retired"}, 32'(result_valid), 32'd0);
    endtask

    initial begin
        int seen;
        idle_inputs();
        rs1_data_ex    = 32'd0;
        rs2_data_ex    = 32'd0;
        alu_result_mem = 32'd0;
        wb_data_wb     = 32'd0;
        rst = 1'b1;
        tick();
        tick();
        chk("reset_stall", 32'(stall_ex), 32'd0);
        chk("reset_valid", 32'(result_valid), 32'd0);
        chk("reset_result", result, 32'd0);
        rst = 1'b0;
        tick();

        // Non-muldiv instruction leaves the unit idle.
        valid_ex = 1'b1;
        is_muldiv_ex = 1'b0;
        #1;
        chk("nonmd_stall", 32'(stall_ex), 32'd0);
        tick();
        chk("nonmd_valid", 32'(result_valid), 32'd0);
        idle_inputs();
        tick();

        // MUL with forwarded operands; sources change after accept.
        valid_ex = 1'b1; is_muldiv_ex = 1'b1; funct3_ex = 3'b000;
        rs1_data_ex = 32'd100; rs2_data_ex = 32'd200;
        alu_result_mem = 32'd7; wb_data_wb = 32'd6;
        forward_a = 2'b01; forward_b = 2'b10;
        #1;
        chk("fwd_stall_t", 32'(stall_ex), 32'd1);
        chk("fwd_valid_t", 32'(result_valid), 32'd0);
        tick();
        alu_result_mem = 32'hDEADBEEF; wb_data_wb = 32'h55;
        #1;
        chk("fwd_stall_t1", 32'(stall_ex), 32'd1);
        tick();
        chk("fwd_valid_t2", 32'(result_valid), 32'd1);
        chk("fwd_result_t2", result, 32'd42);
        chk("fwd_stall_t2", 32'(stall_ex), 32'd0);
        idle_inputs();
        tick();
        chk("fwd_retired", 32'(result_valid), 32'd0);

        // Multiplies.
        run_op("mul_lo",  3'b000, 32'h12345678, 32'h10, 2'b00, 2'b00, 32'h23456780, 2, 0);
        run_op("mulh",    3'b001, 32'h80000000, 32'h80000000, 2'b00, 2'b00, 32'h40000000, 2, 0);
        run_op("mulhsu",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 2'b00, 32'hFFFFFFFF, 2, 0);
        run_op("mulhu",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 2'b00, 32'hFFFFFFFE, 2, 0);
        run_op("mul_sel11", 3'b000, 32'd3, 32'd5, 2'b11, 2'b11, 32'd15, 2, 0);

        // Divides and remainders.
        run_op("div_m7_2",  3'b100, 32'hFFFFFFF9, 32'd2, 2'b00, 2'b00, 32'hFFFFFFFD, 33, 0);
        run_op("rem_m7_2",  3'b110, 32'hFFFFFFF9, 32'd2, 2'b00, 2'b00, 32'hFFFFFFFF, 33, 0);
        run_op("rem_7_m2",  3'b110, 32'd7, 32'hFFFFFFFE, 2'b00, 2'b00, 32'd1, 33, 0);
        run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 2'b00, 2'b00, 32'd14, 33, 0);
        run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 2'b00, 2'b00, 32'd2, 33, 0);
        run_op("divu_3_10", 3'b101, 32'd3, 32'd10, 2'b00, 2'b00, 32'd0, SPECIAL_STALL, 0);
        run_op("remu_3_10", 3'b111, 32'd3, 32'd10, 2'b00, 2'b00, 32'd3, SPECIAL_STALL, 0);
        run_op("divu_5_0",  3'b101, 32'd5, 32'd0, 2'b00, 2'b00, 32'hFFFFFFFF, SPECIAL_STALL, 0);
        run_op("rem_5_0",   3'b110, 32'd5, 32'd0, 2'b00, 2'b00, 32'd5, SPECIAL_STALL, 0);
        run_op("div_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 2'b00, 2'b00, 32'h80000000, SPECIAL_STALL, 0);
        run_op("rem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 2'b00, 2'b00, 32'd0, SPECIAL_STALL, 0);

        // Flush at T+10 of a divide.
        valid_ex = 1'b1; is_muldiv_ex = 1'b1; funct3_ex = 3'b101;
        rs1_data_ex = 32'd1000; rs2_data_ex = 32'd3;
        #1;
        chk("flush_accept_stall", 32'(stall_ex), 32'd1);
        for (int i = 0; i < 10; i++) tick();
        flush_ex = 1'b1;
        tick();
        idle_inputs();
        #1;
        chk("flush_stall", 32'(stall_ex), 32'd0);
        chk("flush_valid", 32'(result_valid), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (result_valid) seen++;
            tick();
        end
        chk("flush_no_result", 32'(seen), 32'd0);
        run_op("mul_after_flush", 3'b000, 32'd9, 32'd11, 2'b00, 2'b00, 32'd99, 2, 0);

        // Hold DONE for 3 cycles.
        run_op("divu_hold", 3'b101, 32'd50, 32'd5, 2'b00, 2'b00, 32'd10, 33, 3);

        // Reset in the middle of a divide.
        valid_ex = 1'b1; is_muldiv_ex = 1'b1; funct3_ex = 3'b100;
        rs1_data_ex = 32'd77; rs2_data_ex = 32'd5;
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        idle_inputs();
        tick();
        chk("rst_mid_stall", 32'(stall_ex), 32'd0);
        chk("rst_mid_valid", 32'(result_valid), 32'd0);
        chk("rst_mid_result", result, 32'd0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (result_valid) seen++;
            tick();
        end
        chk("rst_mid_no_result", 32'(seen), 32'd0);
        run_op("div_after_rst", 3'b100, 32'd77, 32'd5, 2'b00, 2'b00, 32'd15, 33, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
